// File: rtl/pkg_pwm.sv
// Shared PWM types: modulator on/off state and shadow-register update point.
// Imported by every block that drives or consumes the shadow-register interface.
package PKG_pwm;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } _pwm_onoff;

    typedef enum logic [1:0] {
        UPD_ZERO      = 2'd0,
        UPD_MAX       = 2'd1,
        UPD_BOTH      = 2'd2,
        UPD_IMMEDIATE = 2'd3
    } _upd_mode;

    // A zero and a peak pulse in the same cycle count as one update point.
    function automatic logic upd_event(
        input _upd_mode mode,
        input logic     at_zero,
        input logic     at_peak,
        input logic     commit
    );
        case (mode)
            UPD_ZERO: return at_zero;
            UPD_MAX:  return at_peak;
            UPD_BOTH: return at_zero | at_peak;
            default:  return commit;
        endcase
    endfunction

endpackage

// File: rtl/pwm_update_scheduler.sv
// Sequences PWM start/stop against the carrier and schedules shadow-register
// transfers (mask_event) so new duty values land only at the chosen update point.
module pwm_update_scheduler
    import PKG_pwm::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_req,
    input  logic        stop_req,
    input  logic        cnt_zero,
    input  logic        cnt_max,
    input  _upd_mode    upd_mode,
    input  logic        cfg_commit,
    output logic        cfg_ack,
    output logic        mask_event,
    output _pwm_onoff   pwm_onoff,
    output logic        upd_pending,
    output logic [15:0] upd_count
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_mask_event;
    logic        r_cfg_ack;
    logic        r_upd_pending;
    logic [15:0] r_upd_count;
    _pwm_onoff   r_pwm_onoff;

    logic        w_active;
    logic        w_enter_off;
    logic        w_initial_load;
    logic        w_event;
    logic        w_service;
    logic        w_mask_d;
    logic        w_ack_d;
    logic        w_pending_d;
    _pwm_onoff   w_onoff_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output is defaulted first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_OFF: begin
                if (start_req && !stop_req) w_next_state = S_ARM;
            end
            S_ARM: begin
                if (stop_req)      w_next_state = S_OFF;
                else if (cnt_zero) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (stop_req) w_next_state = S_STOP;
            end
            S_STOP: begin
                // Stop only lands at carrier zero; a fresh start cancels it before then.
                if (cnt_zero)                    w_next_state = S_OFF;
                else if (start_req && !stop_req) w_next_state = S_RUN;
            end
            default: w_next_state = S_OFF;
        endcase
    end

    always_comb begin
        w_active       = (r_state == S_RUN) || (r_state == S_STOP);
        w_enter_off    = (r_state != S_OFF) && (w_next_state == S_OFF);
        w_initial_load = (r_state == S_ARM) && (w_next_state == S_RUN);
        w_event        = upd_event(upd_mode, cnt_zero, cnt_max, cfg_commit);

        // Leaving the active states flushes a pending commit without a transfer.
        w_service = w_active && !w_enter_off && w_event && (r_upd_pending || cfg_commit);

        w_mask_d = w_initial_load || w_service;

        // While off the shadow registers are transparent, so a commit is acked at once.
        w_ack_d = (!w_active && cfg_commit)
                || w_service
                || (w_enter_off && (r_upd_pending || cfg_commit));

        w_pending_d = r_upd_pending;
        if (w_enter_off || w_initial_load || w_service) begin
            w_pending_d = 1'b0;
        end else if (w_active && cfg_commit) begin
            w_pending_d = 1'b1;
        end

        w_onoff_d = PWM_OFF;
        if ((w_next_state == S_RUN) || (w_next_state == S_STOP)) begin
            w_onoff_d = PWM_ON;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask_event  <= 1'b0;
            r_cfg_ack     <= 1'b0;
            r_upd_pending <= 1'b0;
            r_pwm_onoff   <= PWM_OFF;
        end else begin
            r_mask_event  <= w_mask_d;
            r_cfg_ack     <= w_ack_d;
            r_upd_pending <= w_pending_d;
            r_pwm_onoff   <= w_onoff_d;
        end
    end

    // Free-running tally of transfers; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_upd_count <= 16'd0;
        end else if (w_mask_d) begin
            r_upd_count <= r_upd_count + 16'd1;
        end
    end

    assign cfg_ack     = r_cfg_ack;
    assign mask_event  = r_mask_event;
    assign pwm_onoff   = r_pwm_onoff;
    assign upd_pending = r_upd_pending;
    assign upd_count   = r_upd_count;

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Self-checking bench for pwm_update_scheduler: directed scenarios, a behavioural
// model compared every cycle, and hand-computed expectations at key cycles.
module tb_pwm_update_scheduler;
    import PKG_pwm::*;

    logic        clk;
    logic        reset;
    logic        start_req;
    logic        stop_req;
    logic        cnt_zero;
    logic        cnt_max;
    _upd_mode    upd_mode;
    logic        cfg_commit;
    logic        cfg_ack;
    logic        mask_event;
    _pwm_onoff   pwm_onoff;
    logic        upd_pending;
    logic [15:0] upd_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pwm_update_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .start_req   (start_req),
        .stop_req    (stop_req),
        .cnt_zero    (cnt_zero),
        .cnt_max     (cnt_max),
        .upd_mode    (upd_mode),
        .cfg_commit  (cfg_commit),
        .cfg_ack     (cfg_ack),
        .mask_event  (mask_event),
        .pwm_onoff   (pwm_onoff),
        .upd_pending (upd_pending),
        .upd_count   (upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: "on" means the modulator runs, "armed" waits for carrier
    // zero, "stopping" waits for carrier zero to switch off.
    bit m_on, m_armed, m_stopping, m_pend, m_mask, m_ack;
    int m_count;

    always @(posedge clk) begin
        bit ev;
        m_mask = 0;
        m_ack  = 0;
        if (reset) begin
            m_on = 0; m_armed = 0; m_stopping = 0; m_pend = 0; m_count = 0;
        end else begin
            ev = (upd_mode == UPD_IMMEDIATE) ? cfg_commit
               : (((upd_mode != UPD_MAX) && cnt_zero) || ((upd_mode != UPD_ZERO) && cnt_max));
            if (!m_on) begin
                if (cfg_commit) m_ack = 1;
                if (m_armed) begin
                    if (stop_req) m_armed = 0;
                    else if (cnt_zero) begin
                        m_armed = 0; m_on = 1; m_mask = 1; m_pend = 0;
                    end
                end else if (start_req && !stop_req) begin
                    m_armed = 1;
                end
            end else if (m_stopping && cnt_zero) begin
                if (m_pend || cfg_commit) m_ack = 1;
                m_on = 0; m_stopping = 0; m_pend = 0;
            end else begin
                if (ev && (m_pend || cfg_commit)) begin
                    m_mask = 1; m_ack = 1; m_pend = 0;
                end else if (cfg_commit) begin
                    m_pend = 1;
                end
                if (m_stopping && start_req && !stop_req) m_stopping = 0;
                else if (!m_stopping && stop_req)         m_stopping = 1;
            end
            if (m_mask) m_count = (m_count + 1) % 65536;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("model_mask_event",  mask_event,       m_mask);
            check("model_cfg_ack",     cfg_ack,          m_ack);
            check("model_upd_pending", upd_pending,      m_pend);
            check("model_pwm_onoff",   pwm_onoff,        m_on);
            check("model_upd_count",   upd_count,        m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic expect_all(input string tag, input logic m, input logic a,
                              input logic p, input logic o, input int c);
        check({tag, ".mask_event"},  mask_event,  m);
        check({tag, ".cfg_ack"},     cfg_ack,     a);
        check({tag, ".upd_pending"}, upd_pending, p);
        check({tag, ".pwm_onoff"},   pwm_onoff,   o);
        check({tag, ".upd_count"},   upd_count,   c);
    endtask

    initial begin
        reset = 1; start_req = 0; stop_req = 0; cnt_zero = 0; cnt_max = 0;
        cfg_commit = 0; upd_mode = UPD_MAX;

        wait_cyc(2);
        expect_all("reset", 0, 0, 0, 0, 0);
        reset = 0;

        // Start, then first carrier zero performs the initial load.
        wait_cyc(3);  start_req = 1; tick(); start_req = 0;
        wait_cyc(10); expect_all("armed", 0, 0, 0, 0, 0);
        cnt_zero = 1; tick(); cnt_zero = 0;
        expect_all("first_on", 1, 0, 0, 1, 1);
        tick(); expect_all("first_on_after", 0, 0, 0, 1, 1);

        // UPD_MAX: two commits absorbed into one transfer at the peak.
        wait_cyc(20); cfg_commit = 1; tick(); cfg_commit = 0;
        expect_all("max_commit1", 0, 0, 1, 1, 1);
        cnt_zero = 1; tick(); cnt_zero = 0;
        tick(); expect_all("max_zero_ignored", 0, 0, 1, 1, 1);
        wait_cyc(25); cfg_commit = 1; tick(); cfg_commit = 0;
        expect_all("max_commit2", 0, 0, 1, 1, 1);
        wait_cyc(40); expect_all("max_still_pending", 0, 0, 1, 1, 1);
        cnt_max = 1; tick(); cnt_max = 0;
        expect_all("max_service", 1, 1, 0, 1, 2);
        tick(); expect_all("max_single_pulse", 0, 0, 0, 1, 2);

        // UPD_IMMEDIATE: the commit is its own update point.
        wait_cyc(44); upd_mode = UPD_IMMEDIATE;
        wait_cyc(45); cfg_commit = 1; tick(); cfg_commit = 0;
        expect_all("immediate", 1, 1, 0, 1, 3);

        // UPD_BOTH: simultaneous zero and peak give one transfer.
        wait_cyc(47); upd_mode = UPD_BOTH;
        wait_cyc(48); cfg_commit = 1; tick(); cfg_commit = 0;
        expect_all("both_pending", 0, 0, 1, 1, 3);
        wait_cyc(50); cnt_zero = 1; cnt_max = 1; tick(); cnt_zero = 0; cnt_max = 0;
        expect_all("both_service", 1, 1, 0, 1, 4);
        tick(); expect_all("both_single_pulse", 0, 0, 0, 1, 4);

        // Stop waits for carrier zero; pending commit is acked on the way out.
        wait_cyc(55); stop_req = 1; tick(); stop_req = 0;
        expect_all("stopping", 0, 0, 0, 1, 4);
        wait_cyc(60); cfg_commit = 1; tick(); cfg_commit = 0;
        expect_all("stop_pending", 0, 0, 1, 1, 4);
        wait_cyc(70); expect_all("stop_still_on", 0, 0, 1, 1, 4);
        cnt_zero = 1; tick(); cnt_zero = 0;
        expect_all("stop_off", 0, 1, 0, 0, 4);
        tick(); expect_all("stop_off_after", 0, 0, 0, 0, 4);

        // Commit while off: ack only.
        wait_cyc(75); cfg_commit = 1; tick(); cfg_commit = 0;
        expect_all("off_commit", 0, 1, 0, 0, 4);

        // start and stop together: stop wins, carrier zero does not start.
        wait_cyc(80); start_req = 1; stop_req = 1; tick(); start_req = 0; stop_req = 0;
        wait_cyc(83); cnt_zero = 1; tick(); cnt_zero = 0;
        expect_all("start_stop_tie", 0, 0, 0, 0, 4);

        // Arm then abort with stop; commit while armed is acked.
        wait_cyc(85); start_req = 1; tick(); start_req = 0;
        cfg_commit = 1; tick(); cfg_commit = 0;
        expect_all("arm_commit", 0, 1, 0, 0, 4);
        stop_req = 1; tick(); stop_req = 0;
        wait_cyc(89); cnt_zero = 1; tick(); cnt_zero = 0;
        expect_all("arm_aborted", 0, 0, 0, 0, 4);

        // Restart, then cancel a stop with start before carrier zero.
        start_req = 1; tick(); start_req = 0;
        wait_cyc(92); cnt_zero = 1; tick(); cnt_zero = 0;
        expect_all("restart", 1, 0, 0, 1, 5);
        wait_cyc(95); stop_req = 1; tick(); stop_req = 0;
        expect_all("stop_again", 0, 0, 0, 1, 5);
        wait_cyc(97); start_req = 1; tick(); start_req = 0;
        expect_all("stop_cancelled", 0, 0, 0, 1, 5);
        wait_cyc(100); cnt_zero = 1; tick(); cnt_zero = 0;
        expect_all("still_running", 0, 0, 0, 1, 5);

        // Reset mid-operation with a pending commit overrides everything.
        wait_cyc(103); upd_mode = UPD_MAX;
        wait_cyc(105); cfg_commit = 1; tick(); cfg_commit = 0;
        expect_all("pre_reset_pending", 0, 0, 1, 1, 5);
        wait_cyc(110); reset = 1; cfg_commit = 1; cnt_max = 1; tick();
        cfg_commit = 0; cnt_max = 0;
        expect_all("mid_reset", 0, 0, 0, 0, 0);
        reset = 0;

        // Counter wrap: 65536 transfers in total return the count to zero.
        wait_cyc(113); start_req = 1; tick(); start_req = 0;
        wait_cyc(115); cnt_zero = 1; tick(); cnt_zero = 0;
        expect_all("wrap_start", 1, 0, 0, 1, 1);
        upd_mode = UPD_IMMEDIATE;
        for (int i = 0; i < 65535; i++) begin
            cfg_commit = 1;
            tick();
            if (i == 65533) check("wrap_ffff", upd_count, 32'h0000_FFFF);
        end
        cfg_commit = 0;
        check("wrap_zero", upd_count, 32'h0000_0000);
        tick();
        expect_all("wrap_idle", 0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
